// File: rtl/shift_add_multiplier_8bit.sv
// Sequential 8x8 unsigned shift-and-add multiplier, one partial-product step
// per clock through a single 8-bit carry-look-ahead adder.
// Optional feature: define ZERO_SKIP_EN to bypass CALC when a or b is zero.

// 8-bit carry-look-ahead adder with 9-bit result (carry-out in bit 8).
module carry_look_ahead_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [8:0] sum
);
  logic [7:0] w_g;
  logic [7:0] w_p;
  logic [8:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Carry chain from generate/propagate terms.
  always_comb begin
    w_c    = '0;
    w_c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end
  end

  assign sum = {w_c[8], w_p ^ w_c[7:0]};
endmodule

// state  | meaning
// S_IDLE | waiting for operands, in_ready=1
// S_CALC | 8 shift-add steps, cnt counts 0..7
// S_DONE | product valid, waiting for out_ready
module shift_add_multiplier_8bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_mcand;
  logic [7:0]  r_acc_hi;
  logic [7:0]  r_acc_lo;
  logic [2:0]  r_cnt;
  logic [15:0] r_prod;
  logic [8:0]  w_sum;
  logic [8:0]  w_s9;
  logic        w_accept;
  logic        w_zero;

  carry_look_ahead_8bit u_cla (
    .a   (r_acc_hi),
    .b   (r_mcand),
    .cin (1'b0),
    .sum (w_sum)
  );

  // Add the multiplicand only when the current multiplier bit is set; the
  // carry-out is kept in bit 8 so it shifts into acc_hi and is never lost.
  assign w_s9     = r_acc_lo[0] ? w_sum : {1'b0, r_acc_hi};
  assign w_accept = in_valid && (r_state == S_IDLE);

`ifdef ZERO_SKIP_EN
  assign w_zero = (a == 8'h00) || (b == 8'h00);
`else
  assign w_zero = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_zero ? S_DONE : S_CALC;
      S_CALC:  if (r_cnt == 3'd7) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, shift-add datapath and product register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_cnt    <= '0;
      r_prod   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_zero) begin
              r_prod <= '0;
            end else begin
              r_mcand  <= a;
              r_acc_hi <= '0;
              r_acc_lo <= b;
              r_cnt    <= '0;
            end
          end
        end
        S_CALC: begin
          r_acc_hi <= w_s9[8:1];
          r_acc_lo <= {w_s9[0], r_acc_lo[7:1]};
          r_cnt    <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) r_prod <= {w_s9[8:1], w_s9[0], r_acc_lo[7:1]};
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = (r_state == S_DONE);
  assign product   = r_prod;
endmodule

// File: tb/tb_shift_add_multiplier_8bit.sv
// Scoreboard bench for shift_add_multiplier_8bit: the driver pushes expected
// products and latencies, a negedge monitor pops and compares on handshake.
module tb_shift_add_multiplier_8bit;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;

  typedef struct {
    logic [15:0] prod;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   n_pushed  = 0;
  int   n_results = 0;
  logic prev_ov   = 1'b0;

  shift_add_multiplier_8bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand pair; push the expectation only when a result is due.
  task automatic send(input logic [7:0] av, input logic [7:0] bv,
                      input logic [15:0] exp, input bit push);
    int   t;
    exp_t e;
    t = 0;
    while (!in_ready && t < 100) begin
      step();
      t++;
    end
    if (!in_ready) begin
      check("send_timeout_in_ready", 0, 1);
    end else begin
      in_valid = 1'b1;
      a = av;
      b = bv;
      if (push) begin
        e.prod = exp;
        e.acc  = cyc;
        e.lat  = 8;
`ifdef ZERO_SKIP_EN
        if (av == 8'h00 || bv == 8'h00) e.lat = 0;
`endif
        q.push_back(e);
        n_pushed++;
      end
      step();
      in_valid = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || !in_ready) && t < 200) begin
      step();
      t++;
    end
    if (q.size() != 0 || !in_ready) check("drain_timeout", 0, 1);
  endtask

  // Monitor: latency on out_valid rise, product on handshake.
  always @(negedge clk) begin
    if (out_valid && !prev_ov) begin
      if (q.size() == 0) check("unexpected_out_valid", 1, 0);
      else check("latency", cyc - q[0].acc - 1, q[0].lat);
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_result", int'(product), -1);
      end else begin
        check("product", int'(product), int'(q[0].prod));
        void'(q.pop_front());
      end
      n_results++;
    end
    prev_ov = out_valid;
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[] = '{
    '{8'hFF, 8'hFF, 16'hFE01},
    '{8'h01, 8'hFF, 16'h00FF},
    '{8'hFF, 8'h01, 16'h00FF},
    '{8'h80, 8'h02, 16'h0100},
    '{8'h10, 8'h10, 16'h0100},
    '{8'hAA, 8'h55, 16'h3872},
    '{8'h0F, 8'h0F, 16'h00E1},
    '{8'h80, 8'h80, 16'h4000},
    '{8'hFE, 8'hFF, 16'hFD02},
    '{8'h7F, 8'h81, 16'h3FFF},
    '{8'hC3, 8'h3C, 16'h2DB4}
  };

  initial begin
    int t;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    out_ready = 1'b1;
    repeat (3) step();
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_product", int'(product), 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);

    // First operation and in_ready return gap.
    send(8'h0D, 8'h0B, 16'h008F, 1);
    t = 0;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    check("in_ready_gap", t, 9);
    drain();

    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].p, 1);
      drain();
    end

    // Backpressure with ignored in_valid pulses.
    out_ready = 1'b0;
    send(8'h12, 8'h34, 16'h03A8, 1);
    t = 0;
    while (!out_valid && t < 20) begin
      step();
      t++;
    end
    check("bp_out_valid_seen", int'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a = 8'h11;
      b = 8'h22;
      step();
      check("bp_hold_valid", int'(out_valid), 1);
      check("bp_hold_product", int'(product), 16'h03A8);
      check("bp_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_release_in_ready", int'(in_ready), 1);
    check("bp_release_out_valid", int'(out_valid), 0);
    drain();

    // Busy ignore.
    send(8'h03, 8'h05, 16'h000F, 1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      a = 8'hAA;
      b = 8'hAA;
      check("busy_in_ready", int'(in_ready), 0);
      step();
    end
    in_valid = 1'b0;
    drain();

    // Reset in the middle of CALC.
    send(8'h80, 8'h80, 16'h0000, 0);
    repeat (3) step();
    rst = 1'b1;
    step();
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_product", int'(product), 0);
    check("midrst_in_ready", int'(in_ready), 0);
    rst = 1'b0;
    #1;
    check("midrst_release_in_ready", int'(in_ready), 1);
    repeat (12) step();
    check("midrst_no_result", int'(out_valid), 0);
    send(8'h02, 8'h03, 16'h0006, 1);
    drain();

    // Zero operands.
    send(8'h00, 8'h5A, 16'h0000, 1);
    drain();
    send(8'h5A, 8'h00, 16'h0000, 1);
    drain();

    step();
    check("result_count", n_results, n_pushed);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
